mandelbrot_frame_ctrl: RTL

Frame sequencer and configuration owner for the `mandelbrot` iteration engine. It latches host configuration into shadow registers and applies it only at frame boundaries. It launches frames (single-shot or continuous), tracks pixel coordinates from the engine's `new_ctr` pulses, and reports frame completion and pixel-count errors. It sits between the host/register interface and the engine, with the pixel output heading to the display buffer.

---
 rtl/mandelbrot_frame_ctrl_if.sv | 46 ++++
 rtl/mandelbrot_frame_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_frame_ctrl_if.sv
// Signal bundle between the frame controller, the host register block and the mandelbrot engine.
// slave = controller view, master = host/engine/display view.
interface mandelbrot_frame_ctrl_if #(
  parameter int CTRWIDTH = 4
);
  logic [CTRWIDTH-1:0] cfg_max_ctr;
  logic [1:0]          cfg_ctr_select;
  logic                cfg_write;
  logic                start;
  logic                continuous;
  logic                abort;
  logic                eng_run;
  logic                eng_reset;
  logic [CTRWIDTH-1:0] eng_max_ctr;
  logic [1:0]          eng_ctr_select;
  logic                eng_running;
  logic                eng_new_ctr;
  logic [3:0]          eng_ctr_out;
  // All transfers are strobes with no backpressure: eng_new_ctr and pix_valid each
  // carry exactly one pixel per cycle they are high, and the receiver must take it.
  logic                pix_valid;
  logic [9:0]          pix_x;
  logic [8:0]          pix_y;
  logic [3:0]          pix_val;
  logic                busy;
  logic                frame_done;
  logic [7:0]          frame_count;
  logic                count_err;
  logic                wdt_err;

  modport slave (
    input  cfg_max_ctr, cfg_ctr_select, cfg_write, start, continuous, abort,
    input  eng_running, eng_new_ctr, eng_ctr_out,
    output eng_run, eng_reset, eng_max_ctr, eng_ctr_select,
    output pix_valid, pix_x, pix_y, pix_val,
    output busy, frame_done, frame_count, count_err, wdt_err
  );

  modport master (
    output cfg_max_ctr, cfg_ctr_select, cfg_write, start, continuous, abort,
    output eng_running, eng_new_ctr, eng_ctr_out,
    input  eng_run, eng_reset, eng_max_ctr, eng_ctr_select,
    input  pix_valid, pix_x, pix_y, pix_val,
    input  busy, frame_done, frame_count, count_err, wdt_err
  );
endinterface

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame sequencer for the mandelbrot engine: shadow config, launch, pixel coordinates, status.
// Optional RUN-state stall watchdog enabled by defining MANDELBROT_WATCHDOG_EN.
module mandelbrot_frame_ctrl #(
  parameter int CTRWIDTH = 4,
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int WDT_BITS = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  mandelbrot_frame_ctrl_if.slave bus,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam int FRAME_PIX = H_PIXELS * V_PIXELS;
  localparam int CNT_W     = $clog2(FRAME_PIX + 2);
  localparam logic [9:0]       X_LAST    = 10'(H_PIXELS - 1);
  localparam logic [8:0]       Y_LAST    = 9'(V_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CTRWIDTH-1:0] pend_max_q, act_max_q, act_max_d;
  logic [1:0]          pend_sel_q, act_sel_q, act_sel_d;
  logic [9:0]          x_q, x_d, pix_x_q, pix_x_d;
  logic [8:0]          y_q, y_d, pix_y_q, pix_y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          wait_q, wait_d;
  logic                pix_valid_q, pix_valid_d;
  logic [3:0]          pix_val_q, pix_val_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                count_err_q, count_err_d;
  logic                eng_reset_q;
  logic                frame_done_c;
  logic                launch;
  logic                wdt_fire;
  logic                abort_req;

  // Host writes land in the pending copy at any time; the engine only sees them at ARM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_max_q <= '0;
      pend_sel_q <= '0;
    end else if (bus.cfg_write) begin
      pend_max_q <= bus.cfg_max_ctr;
      pend_sel_q <= bus.cfg_ctr_select;
    end
  end

  assign abort_req = (bus.abort && (state_q inside {S_ARM, S_WAIT, S_RUN, S_DONE})) || wdt_fire;

  always_comb begin
    state_d      = state_q;
    act_max_d    = act_max_q;
    act_sel_d    = act_sel_q;
    x_d          = x_q;
    y_d          = y_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_val_d    = pix_val_q;
    frame_cnt_d  = frame_cnt_q;
    count_err_d  = count_err_q;
    frame_done_c = 1'b0;
    launch       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ARM;
          launch  = 1'b1;
        end
      end
      S_ARM: begin
        x_d     = '0;
        y_d     = '0;
        cnt_d   = '0;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_running) begin
          state_d = S_RUN;
        end else if (wait_q == 2'd3) begin
          state_d     = S_IDLE;
          count_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_RUN: begin
        if (bus.eng_new_ctr) begin
          pix_valid_d = 1'b1;
          pix_x_d     = x_q;
          pix_y_d     = y_q;
          pix_val_d   = bus.eng_ctr_out;
          if (x_q == X_LAST) begin
            x_d = '0;
            // Overlong frames pile up on the last row rather than wrapping.
            if (y_q != Y_LAST) y_d = y_q + 9'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
        end
        if (!bus.eng_running) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done_c = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        if (cnt_q != CNT_FRAME) count_err_d = 1'b1;
        state_d = bus.continuous ? S_ARM : S_IDLE;
      end
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort beats completion: no done pulse, no count update, no stray pixel.
    if (abort_req) begin
      state_d      = S_ABORT;
      pix_valid_d  = 1'b0;
      frame_done_c = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      count_err_d  = count_err_q;
    end

    if (launch) count_err_d = 1'b0;

    if (state_d == S_ARM && state_q != S_ARM) begin
      act_max_d = pend_max_q;
      act_sel_d = pend_sel_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      act_max_q   <= '0;
      act_sel_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      wait_q      <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_val_q   <= '0;
      frame_cnt_q <= '0;
      count_err_q <= 1'b0;
      eng_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      act_max_q   <= act_max_d;
      act_sel_q   <= act_sel_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_val_q   <= pix_val_d;
      frame_cnt_q <= frame_cnt_d;
      count_err_q <= count_err_d;
      eng_reset_q <= (state_d == S_ABORT);
    end
  end

`ifdef MANDELBROT_WATCHDOG_EN
  logic [WDT_BITS-1:0] wdt_q;
  logic                wdt_err_q;

  assign wdt_fire = (state_q == S_RUN) && !bus.eng_new_ctr && (&wdt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      if (state_q != S_RUN || bus.eng_new_ctr) wdt_q <= '0;
      else                                     wdt_q <= wdt_q + 1'b1;
      if (launch)        wdt_err_q <= 1'b0;
      else if (wdt_fire) wdt_err_q <= 1'b1;
    end
  end

  assign bus.wdt_err = wdt_err_q;
`else
  assign wdt_fire    = 1'b0;
  assign bus.wdt_err = 1'b0;
`endif

  assign bus.eng_run        = (state_q == S_ARM);
  assign bus.eng_reset      = eng_reset_q;
  assign bus.eng_max_ctr    = act_max_q;
  assign bus.eng_ctr_select = act_sel_q;
  assign bus.pix_valid      = pix_valid_q;
  assign bus.pix_x          = pix_x_q;
  assign bus.pix_y          = pix_y_q;
  assign bus.pix_val        = pix_val_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.frame_done     = frame_done_c;
  assign bus.frame_count    = frame_cnt_q;
  assign bus.count_err      = count_err_q;
  assign dbg_state_o        = state_q;

endmodule
